uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- UART-driven debug and program-load initiator for the native valid/ready memory bus.
- Parses framed command bytes from the uart_rx byte interface.
- Issues one 32-bit read or write bus transaction per command, then returns the response bytes through the uart_tx byte interface.
- Sits beside the CPU as a second bus initiator; the top-level arbitration holds the CPU off while busy is high.

Parameters:
- TIMEOUT, 1024, bus-wait cycles allowed before a transaction is abandoned (1..65535).
- RX_GAP, 2_500_000, idle cycles between command bytes before a partial frame is discarded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_dout  in  8  received byte from uart_rx
- rx_full  in  1  uart_rx holds an unread byte
- rx_re  out  1  one-cycle pulse; consumes rx_dout
- tx_din  out  8  byte to transmit
- tx_we  out  1  one-cycle pulse; loads tx_din into uart_tx
- tx_empty  in  1  uart_tx can accept a byte
- mem_valid  out  1  bus request
- mem_ready  in  1  responder completes the transaction
- mem_addr  out  32  byte address, word aligned
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF for write, 4'h0 for read
- mem_rdata  in  32  read data, valid when mem_ready is high
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - rx_re, tx_we, mem_valid, busy = 0.
  - mem_addr, mem_wdata, tx_din = 0; mem_wstrb = 0.
  - Byte counter and timers cleared.
- Frame format (all multi-byte fields little-endian):
  - Command byte: 0x57 'W' or 0x52 'R'.
  - Then 4 address bytes.
  - 'W' only: then 4 data bytes.
  - Address bits [1:0] are forced to 0 on mem_addr.
- Byte consume rule:
  - While in a receive state and rx_full=1, assert rx_re for exactly one cycle and latch rx_dout in that same cycle.
  - rx_full is not sampled in the following cycle, which gives uart_rx time to clear.
- Byte transmit rule:
  - While in TX and tx_empty=1, assert tx_we for one cycle with tx_din valid.
  - tx_empty is not sampled in the following cycle.
- States:
  - IDLE: wait for a byte.
    - 'W' or 'R': latch op, go to ADDR with count=0.
    - Any other byte: queue response 0x3F '?' and go to TX.
  - ADDR: collect 4 bytes into address bits [7:0], [15:8], [23:16], [31:24] in order. After the 4th byte: 'W' goes to DATA, 'R' goes to BUS.
  - DATA: collect 4 bytes into mem_wdata in the same order, then go to BUS.
  - BUS:
    - mem_valid=1; mem_addr, mem_wdata, mem_wstrb held stable until completion.
    - mem_ready=1 in any cycle, including the first BUS cycle: mem_valid drops the next cycle.
      - Read: latch mem_rdata as the 4 response bytes (LSB first).
      - Write: the response is 0x4B 'K'.
    - Timer reaches TIMEOUT cycles without mem_ready: drop mem_valid, response is 0x21 '!'.
    - Go to TX.
  - TX: send 1 byte ('K', '?', '!') or 4 bytes (read data), then go to IDLE.
- RX gap timeout:
  - Applies in ADDR and DATA only.
  - The gap counter resets on each consumed byte.
  - Reaching RX_GAP: discard the frame and return to IDLE silently; no response.
- rx_full held high while in BUS or TX: the byte is not consumed (rx_re=0); it is processed after returning to IDLE.
- mem_ready when mem_valid=0: ignored.
- tx_empty low indefinitely: stay in TX, with no timeout.
- busy:
  - Combinational from state; high from the cycle after the command byte is consumed.
  - Low again in the cycle after the last tx_we.
- Reset asserted mid-transaction: mem_valid and all strobes clear immediately and asynchronously; the partial frame is lost.

Test Plan:
- Write: send 57 00 10 00 00 EF BE AD DE, responder asserts mem_ready 2 cycles after mem_valid.
  - Required: one transaction with mem_addr=0x00001000, mem_wdata=0xDEADBEEF, mem_wstrb=F.
  - Required: mem_valid high exactly 3 cycles; tx byte 0x4B.
- Read: send 52 04 20 00 00, responder returns 0x12345678 with same-cycle mem_ready.
  - Required: mem_addr=0x00002004, mem_wstrb=0.
  - Required: tx bytes 78 56 34 12 in order; busy low after the last one.
- Unknown command: send byte 0x41.
  - Required: no mem_valid; tx byte 0x3F; return to IDLE.
- Timeout: TIMEOUT=16, read with mem_ready held low.
  - Required: mem_valid high exactly 16 cycles, then low; tx byte 0x21.
- Gap and alignment:
  - RX_GAP=100: send 57 03 10 then stall 100 cycles. Required: silent return to IDLE.
  - Then send a read to address 0x00001003. Required: mem_addr=0x00001000.
- Reset and flow control:
  - Assert rst_n low during BUS. Required: mem_valid=0 asynchronously and all outputs at reset values.
  - Hold tx_empty low during a read response. Required: tx_we never pulses until tx_empty rises, and each pulse is followed by one non-sampling cycle.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART command parser that issues one 32-bit read or write on the native valid/ready bus per frame
// and returns the response bytes over uart_tx.
module uart_bus_master #(
  parameter int TIMEOUT = 1024,
  parameter int RX_GAP  = 2_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_dout,
  input  logic        rx_full,
  output logic        rx_re,
  output logic [7:0]  tx_din,
  output logic        tx_we,
  input  logic        tx_empty,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, TX} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST = 32'(RX_GAP - 1);

  state_t      state;
  logic        is_wr;
  logic [1:0]  cnt;
  logic        rx_hold;
  logic        tx_hold;
  logic [15:0] timer;
  logic [31:0] gap;
  logic [31:0] resp;
  logic [1:0]  tx_left;

  assign busy = (state != IDLE);

  // rx_re/tx_we are registered: the byte is taken (or handed over) in the cycle the pulse is
  // visible, and the cycle after it is a hold-off so the peer's flag has time to clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      cnt       <= '0;
      rx_hold   <= 1'b0;
      tx_hold   <= 1'b0;
      timer     <= '0;
      gap       <= '0;
      resp      <= '0;
      tx_left   <= '0;
      rx_re     <= 1'b0;
      tx_we     <= 1'b0;
      tx_din    <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      rx_re   <= 1'b0;
      tx_we   <= 1'b0;
      rx_hold <= rx_re;
      tx_hold <= tx_we;
      case (state)
        IDLE: begin
          if (rx_re) begin
            if (rx_dout == 8'h57 || rx_dout == 8'h52) begin
              is_wr <= (rx_dout == 8'h57);
              cnt   <= '0;
              gap   <= '0;
              state <= ADDR;
            end else begin
              resp    <= 32'h0000_003F;
              tx_left <= '0;
              state   <= TX;
            end
          end else if (rx_full && !rx_hold) begin
            rx_re <= 1'b1;
          end
        end
        ADDR, DATA: begin
          if (rx_re) begin
            if (state == ADDR)
              mem_addr[{cnt, 3'b000} +: 8] <= (cnt == 2'd0) ? (rx_dout & 8'hFC) : rx_dout;
            else
              mem_wdata[{cnt, 3'b000} +: 8] <= rx_dout;
            cnt <= cnt + 2'd1;
            gap <= '0;
            if (cnt == 2'd3) begin
              if (state == ADDR && is_wr) begin
                state <= DATA;
              end else begin
                state     <= BUS;
                mem_valid <= 1'b1;
                mem_wstrb <= is_wr ? 4'hF : 4'h0;
                timer     <= '0;
              end
            end
          end else if (gap == GAP_LAST) begin
            // stalled sender: drop the partial frame without answering
            state <= IDLE;
          end else begin
            gap <= gap + 32'd1;
            if (rx_full && !rx_hold) rx_re <= 1'b1;
          end
        end
        BUS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
            resp      <= is_wr ? 32'h0000_004B : mem_rdata;
            tx_left   <= is_wr ? 2'd0 : 2'd3;
            state     <= TX;
          end else if (timer == TMO_LAST) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
            resp      <= 32'h0000_0021;
            tx_left   <= '0;
            state     <= TX;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        TX: begin
          if (tx_we) begin
            resp <= resp >> 8;
            if (tx_left == 2'd0) state <= IDLE;
            else                 tx_left <= tx_left - 2'd1;
          end else if (tx_empty && !tx_hold) begin
            tx_we  <= 1'b1;
            tx_din <= resp[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: write, read, unknown command, bus timeout, rx gap,
// address alignment, async reset mid-transaction and tx flow control.
module tb_uart_bus_master;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_dout;
  logic        rx_full;
  logic        rx_re;
  logic [7:0]  tx_din;
  logic        tx_we;
  logic        tx_empty;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  uart_bus_master #(.TIMEOUT(16), .RX_GAP(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_dout(rx_dout), .rx_full(rx_full), .rx_re(rx_re),
    .tx_din(tx_din), .tx_we(tx_we), .tx_empty(tx_empty),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bus / tx monitors
  int          vcnt_total = 0;
  int          tx_total   = 0;
  int          tx_viol    = 0;
  int          stab_viol  = 0;
  logic        valid_d    = 1'b0;
  logic        tx_we_d    = 1'b0;
  logic        tx_empty_d = 1'b1;
  logic [31:0] v_addr  = '0;
  logic [31:0] v_wdata = '0;
  logic [3:0]  v_wstrb = '0;

  always @(negedge clk) begin
    if (mem_valid) begin
      vcnt_total <= vcnt_total + 1;
      if (!valid_d) begin
        v_addr  <= mem_addr;
        v_wdata <= mem_wdata;
        v_wstrb <= mem_wstrb;
      end else if (mem_addr != v_addr || mem_wdata != v_wdata || mem_wstrb != v_wstrb) begin
        stab_viol <= stab_viol + 1;
      end
    end
    if (tx_we) tx_total <= tx_total + 1;
    if (tx_we && (tx_we_d || !tx_empty_d)) tx_viol <= tx_viol + 1;
    valid_d    <= mem_valid;
    tx_we_d    <= tx_we;
    tx_empty_d <= tx_empty;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    rx_dout = b;
    rx_full = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rx_re) seen = 1'b1;
    end
    chk("rx_re_seen", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1 rx_full = 1'b0;
  endtask

  task automatic wait_valid();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid) seen = 1'b1;
    end
    chk("mem_valid_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic collect_tx(input int n, output logic [31:0] data, output logic busy_after);
    int got;
    got = 0;
    data = '0;
    busy_after = 1'b1;
    for (int i = 0; i < 300 && got < n; i++) begin
      @(negedge clk);
      if (tx_we) begin
        data[8*got +: 8] = tx_din;
        got++;
      end
    end
    chk("tx_count", got, n);
    if (got == n) begin
      chk("busy_on_last_we", {31'b0, busy}, 32'd1);
      @(negedge clk);
      busy_after = busy;
    end
  endtask

  logic [31:0] data;
  logic        b_after;
  int          v0;
  int          t0;

  initial begin
    rst_n = 1'b0; rx_dout = '0; rx_full = 1'b0; tx_empty = 1'b1;
    mem_ready = 1'b0; mem_rdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_rx_re",     {31'b0, rx_re},     32'd0);
    chk("rst_tx_we",     {31'b0, tx_we},     32'd0);
    chk("rst_mem_addr",  mem_addr,           32'd0);
    chk("rst_tx_din",    {24'b0, tx_din},    32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write, ready two cycles after valid
    v0 = vcnt_total;
    send_byte(8'h57);
    chk("wr_busy_after_cmd", {31'b0, busy}, 32'd1);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_valid();
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    collect_tx(1, data, b_after);
    chk("wr_resp",       data,         32'h0000_004B);
    chk("wr_busy_after", {31'b0, b_after}, 32'd0);
    chk("wr_valid_cycles", vcnt_total - v0, 32'd3);
    chk("wr_addr",  v_addr,  32'h0000_1000);
    chk("wr_wdata", v_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", {28'b0, v_wstrb}, 32'hF);

    // read, same-cycle ready
    v0 = vcnt_total;
    send_byte(8'h52); send_byte(8'h04); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
    wait_valid();
    chk("rd_addr",  mem_addr, 32'h0000_2004);
    chk("rd_wstrb", {28'b0, mem_wstrb}, 32'h0);
    mem_rdata = 32'h1234_5678;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    collect_tx(4, data, b_after);
    chk("rd_resp",       data, 32'h1234_5678);
    chk("rd_busy_after", {31'b0, b_after}, 32'd0);
    chk("rd_valid_cycles", vcnt_total - v0, 32'd1);

    // unknown command
    v0 = vcnt_total;
    send_byte(8'h41);
    collect_tx(1, data, b_after);
    chk("unk_resp",       data, 32'h0000_003F);
    chk("unk_busy_after", {31'b0, b_after}, 32'd0);
    chk("unk_no_valid",   vcnt_total - v0, 32'd0);

    // bus timeout
    v0 = vcnt_total;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h30); send_byte(8'h00); send_byte(8'h00);
    wait_valid();
    collect_tx(1, data, b_after);
    chk("tmo_resp",         data, 32'h0000_0021);
    chk("tmo_valid_cycles", vcnt_total - v0, 32'd16);
    chk("tmo_busy_after",   {31'b0, b_after}, 32'd0);

    // rx gap discards the partial frame silently
    t0 = tx_total;
    send_byte(8'h57); send_byte(8'h03); send_byte(8'h10);
    chk("gap_busy_mid", {31'b0, busy}, 32'd1);
    repeat (105) @(negedge clk);
    chk("gap_idle",  {31'b0, busy}, 32'd0);
    chk("gap_no_tx", tx_total - t0, 32'd0);

    // alignment: low address bits dropped
    send_byte(8'h52); send_byte(8'h03); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    wait_valid();
    chk("align_addr", mem_addr, 32'h0000_1000);
    mem_rdata = 32'h0BAD_F00D;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    collect_tx(4, data, b_after);
    chk("align_resp", data, 32'h0BAD_F00D);

    // async reset during BUS
    send_byte(8'h57); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("arst_busy",      {31'b0, busy},      32'd0);
    chk("arst_mem_addr",  mem_addr,           32'd0);
    chk("arst_mem_wdata", mem_wdata,          32'd0);
    chk("arst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("arst_tx_we",     {31'b0, tx_we},     32'd0);
    chk("arst_rx_re",     {31'b0, rx_re},     32'd0);
    chk("arst_tx_din",    {24'b0, tx_din},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // tx flow control
    tx_empty = 1'b0;
    send_byte(8'h52); send_byte(8'h0C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_valid();
    mem_rdata = 32'hA1B2_C3D4;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    t0 = tx_total;
    repeat (20) @(negedge clk);
    chk("fc_no_tx",   tx_total - t0, 32'd0);
    chk("fc_busy",    {31'b0, busy}, 32'd1);
    tx_empty = 1'b1;
    collect_tx(4, data, b_after);
    chk("fc_resp",       data, 32'hA1B2_C3D4);
    chk("fc_busy_after", {31'b0, b_after}, 32'd0);

    repeat (3) @(negedge clk);
    chk("tx_pulse_rule", tx_viol,   32'd0);
    chk("bus_stable",    stab_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
